// File: rtl/tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tx_arbiter
//  Description : Round-robin packet arbiter feeding a byte-wide UART
//                transmitter. Each granted packet is prefixed with a header
//                byte (8'hA0 | owner index), after which the owner's byte
//                stream passes straight through to the TX port until its
//                last byte is accepted.
//                Optional stall watchdog: define TX_ARB_TIMEOUT_EN to abort
//                a packet (sending 8'hFF) whose owner stalls for TIMEOUT
//                cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [NREQ-1:0]     grant,
    output logic                aborted
);

    localparam int c_IW = (NREQ > 2) ? 2 : 1;

    // Reject out-of-range configurations at elaboration time.
    generate
        if (NREQ < 2 || NREQ > 4 || TIMEOUT < 1) begin : g_bad_params
            $error("tx_arbiter: NREQ must be 2..4 and TIMEOUT at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
`ifdef TX_ARB_TIMEOUT_EN
        S_DATA   = 2'd2,
        S_ABORT  = 2'd3
`else
        S_DATA   = 2'd2
`endif
    } t_state;

    t_state            r_state;
    logic [NREQ-1:0]   r_grant;
    logic [c_IW-1:0]   r_owner;
    logic [c_IW-1:0]   r_last_grant;

    logic              w_any;
    logic [c_IW-1:0]   w_winner;
    logic              w_sel_valid;
    logic              w_sel_last;
    logic [7:0]        w_sel_data;
    logic              w_xfer;

`ifdef TX_ARB_TIMEOUT_EN
    localparam int c_CW = $clog2(TIMEOUT + 1);
    logic [c_CW-1:0]   r_stall;
    logic              r_aborted;
    assign aborted = r_aborted;
`else
    assign aborted = 1'b0;
`endif

    assign grant  = r_grant;
    assign w_xfer = w_sel_valid & tx_ready;

    // Round-robin search: first valid requester after the previous owner.
    always_comb begin
        int v_idx;
        w_any    = 1'b0;
        w_winner = '0;
        v_idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            v_idx = (int'(r_last_grant) + k) % NREQ;
            if (!w_any && req_valid[c_IW'(v_idx)]) begin
                w_any    = 1'b1;
                w_winner = c_IW'(v_idx);
            end
        end
    end

    // Select the current owner's byte stream; all other requesters are ignored.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == c_IW'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
                w_sel_data  = req_data[8*i +: 8];
            end
        end
    end

    // TX and requester handshakes; DATA is a combinational pass-through.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = '0;
        case (r_state)
            S_HEADER: begin
                tx_valid = 1'b1;
                tx_data  = 8'hA0 | 8'(r_owner);
            end
            S_DATA: begin
                tx_valid  = w_sel_valid;
                tx_data   = w_sel_data;
                req_ready = r_grant & {NREQ{tx_ready}};
            end
`ifdef TX_ARB_TIMEOUT_EN
            S_ABORT: begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end
`endif
            default: begin
                tx_valid  = 1'b0;
                tx_data   = 8'h00;
                req_ready = '0;
            end
        endcase
    end

    // Packet sequencing: arbitrate, send header, stream data, release grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_grant <= c_IW'(NREQ - 1);
`ifdef TX_ARB_TIMEOUT_EN
            r_stall      <= '0;
            r_aborted    <= 1'b0;
`endif
        end else begin
`ifdef TX_ARB_TIMEOUT_EN
            r_aborted <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_winner;
                        r_grant <= {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
                        r_state <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (tx_ready) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_xfer && w_sel_last) begin
                        r_last_grant <= r_owner;
                        r_grant      <= '0;
                        r_state      <= S_IDLE;
                    end
`ifdef TX_ARB_TIMEOUT_EN
                    // Stall watchdog: counts owner-idle cycles, any transfer restarts it.
                    if (w_xfer) begin
                        r_stall <= '0;
                    end else if (!w_sel_valid) begin
                        if (r_stall == c_CW'(TIMEOUT - 1)) begin
                            r_stall <= '0;
                            r_state <= S_ABORT;
                        end else begin
                            r_stall <= r_stall + 1'b1;
                        end
                    end
`endif
                end
`ifdef TX_ARB_TIMEOUT_EN
                S_ABORT: begin
                    if (tx_ready) begin
                        r_aborted    <= 1'b1;
                        r_last_grant <= r_owner;
                        r_grant      <= '0;
                        r_state      <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_arbiter
//  Description : Self-checking bench for tx_arbiter (NREQ=3, TIMEOUT=8).
//                Cycle vector table for single-packet and header-stall
//                sequences, plus a requester model with a TX-byte scoreboard
//                for multi-packet, reset and stall sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_arbiter;

    localparam int NREQ = 3;
    localparam int c_TO = 8;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [NREQ-1:0]   grant;
    logic              aborted;

    tx_arbiter #(.NREQ(NREQ), .TIMEOUT(c_TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .aborted   (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  rv;
        logic [23:0] rd;
        logic [2:0]  rl;
        logic        tr;
        logic        tv;
        logic [7:0]  td;
        logic [2:0]  g;
        logic [2:0]  rr;
    } vec_t;

    vec_t        vecs [0:15];
    int          nv;

    int          n_tests;
    int          n_fail;

    logic [8:0]  rmem [0:NREQ-1][0:15];
    int          rhead [0:NREQ-1];
    int          rtail [0:NREQ-1];
    logic [7:0]  exp_q [$];

    logic        rnd_rdy;
    logic        hold_prev;
    logic [7:0]  hold_data;
    int          stall_cycles;
    int          abort_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [2:0] rv, input logic [23:0] rd, input logic [2:0] rl,
                           input logic tr, input logic tv, input logic [7:0] td,
                           input logic [2:0] g, input logic [2:0] rr);
        vecs[nv] = '{rv, rd, rl, tr, tv, td, g, rr};
        nv++;
    endtask

    task automatic push_req(input int r, input logic [7:0] d, input logic l);
        rmem[r][rtail[r]] = {l, d};
        rtail[r]++;
    endtask

    task automatic flush_req(input int r);
        rhead[r] = rtail[r];
    endtask

    // Present each requester's head-of-queue byte.
    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (rhead[i] < rtail[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = rmem[i][rhead[i]][7:0];
                req_last[i]        = rmem[i][rhead[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    function automatic logic queues_empty();
        logic e;
        e = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (rhead[i] < rtail[i]) e = 1'b0;
        end
        return e;
    endfunction

    // One clock of the requester model plus TX monitor/scoreboard.
    task automatic cycle();
        logic [NREQ-1:0] take;
        @(negedge clk);
        take = req_valid & req_ready;
        if (hold_prev) begin
            chk("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
            chk("tx_hold_data", {24'd0, tx_data}, {24'd0, hold_data});
        end
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL tx_unexpected: got %0h expected no byte at %0t", tx_data, $time);
            end else begin
                chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        chk("grant_onehot", {31'd0, $onehot0(grant)}, 32'd1);
        if (grant == 3'b100 && !tx_valid) stall_cycles++;
        if (aborted) abort_cnt++;
        hold_prev = tx_valid && !tx_ready && !reset;
        hold_data = tx_data;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (take[i]) rhead[i]++;
        end
        if (rnd_rdy) tx_ready = 1'($urandom_range(0, 1));
        drive();
    endtask

    // Run until the scoreboard is empty (and optionally the arbiter is idle).
    task automatic drain(input int budget, input logic want_idle);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || (want_idle && (!queues_empty() || grant != '0)))
               && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_in_budget", {31'd0, (n < budget)}, 32'd1);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_grant", {29'd0, grant}, 32'd0);
        chk("rst_req_ready", {29'd0, req_ready}, 32'd0);
        chk("rst_aborted", {31'd0, aborted}, 32'd0);
        reset     = 1'b0;
        hold_prev = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        nv           = 0;
        rnd_rdy      = 1'b0;
        hold_prev    = 1'b0;
        hold_data    = 8'h00;
        stall_cycles = 0;
        abort_cnt    = 0;
        for (int i = 0; i < NREQ; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end

        // Requester 0 sends 31, 32(last): expect A0,31,32, grant 001 for 3 cycles.
        add_vec(3'b001, 24'h000031, 3'b000, 1'b1, 1'b0, 8'h00, 3'b000, 3'b000);
        add_vec(3'b001, 24'h000031, 3'b000, 1'b1, 1'b1, 8'hA0, 3'b001, 3'b000);
        add_vec(3'b001, 24'h000031, 3'b000, 1'b1, 1'b1, 8'h31, 3'b001, 3'b001);
        add_vec(3'b001, 24'h000032, 3'b001, 1'b1, 1'b1, 8'h32, 3'b001, 3'b001);
        add_vec(3'b000, 24'h000000, 3'b000, 1'b1, 1'b0, 8'h00, 3'b000, 3'b000);
        // Requester 1 with tx_ready low for 5 header cycles, then a stalled data byte.
        add_vec(3'b010, 24'h005500, 3'b010, 1'b0, 1'b0, 8'h00, 3'b000, 3'b000);
        for (int i = 0; i < 5; i++)
            add_vec(3'b010, 24'h005500, 3'b010, 1'b0, 1'b1, 8'hA1, 3'b010, 3'b000);
        add_vec(3'b010, 24'h005500, 3'b010, 1'b1, 1'b1, 8'hA1, 3'b010, 3'b000);
        add_vec(3'b011, 24'h005566, 3'b011, 1'b0, 1'b1, 8'h55, 3'b010, 3'b000);
        add_vec(3'b011, 24'h005566, 3'b011, 1'b1, 1'b1, 8'h55, 3'b010, 3'b010);
        add_vec(3'b000, 24'h000000, 3'b000, 1'b1, 1'b0, 8'h00, 3'b000, 3'b000);

        do_reset();

        for (int i = 0; i < nv; i++) begin
            req_valid = vecs[i].rv;
            req_data  = vecs[i].rd;
            req_last  = vecs[i].rl;
            tx_ready  = vecs[i].tr;
            @(negedge clk);
            chk($sformatf("vec%0d_tx_valid", i), {31'd0, tx_valid}, {31'd0, vecs[i].tv});
            chk($sformatf("vec%0d_tx_data", i), {24'd0, tx_data}, {24'd0, vecs[i].td});
            chk($sformatf("vec%0d_grant", i), {29'd0, grant}, {29'd0, vecs[i].g});
            chk($sformatf("vec%0d_req_ready", i), {29'd0, req_ready}, {29'd0, vecs[i].rr});
            @(posedge clk);
            #1;
        end

        // Three single-byte packets in round-robin order.
        do_reset();
        tx_ready = 1'b1;
        push_req(0, 8'h11, 1'b1);
        push_req(1, 8'h22, 1'b1);
        push_req(2, 8'h33, 1'b1);
        exp_q = '{8'hA0, 8'h11, 8'hA1, 8'h22, 8'hA2, 8'h33};
        drive();
        drain(100, 1'b1);

        // Requester 0 re-requests at once; it waits for 1 and 2, pointer wraps.
        push_req(0, 8'h11, 1'b1);
        push_req(0, 8'h44, 1'b1);
        push_req(1, 8'h22, 1'b1);
        push_req(2, 8'h33, 1'b1);
        exp_q = '{8'hA0, 8'h11, 8'hA1, 8'h22, 8'hA2, 8'h33, 8'hA0, 8'h44};
        rnd_rdy = 1'b1;
        drive();
        drain(400, 1'b1);
        rnd_rdy  = 1'b0;
        tx_ready = 1'b1;

        // Reset after requester 1's header and first data byte.
        push_req(1, 8'h5A, 1'b0);
        push_req(1, 8'h5B, 1'b0);
        push_req(1, 8'h5C, 1'b1);
        exp_q = '{8'hA1, 8'h5A};
        drive();
        drain(50, 1'b0);
        reset    = 1'b1;
        tx_ready = 1'b0;
        cycle();
        chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("mid_rst_grant", {29'd0, grant}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) flush_req(i);
        push_req(0, 8'h77, 1'b1);
        push_req(1, 8'h66, 1'b1);
        exp_q    = '{8'hA0, 8'h77, 8'hA1, 8'h66};
        tx_ready = 1'b1;
        drive();
        drain(100, 1'b1);

        // Requester 2 stalls after its header.
        push_req(2, 8'h98, 1'b0);
        exp_q = '{8'hA2};
        drive();
        drain(50, 1'b0);
        flush_req(2);
        drive();
        stall_cycles = 0;
        abort_cnt    = 0;
`ifdef TX_ARB_TIMEOUT_EN
        push_req(0, 8'h42, 1'b1);
        exp_q = '{8'hFF, 8'hA0, 8'h42};
        drive();
        drain(200, 1'b1);
        chk("abort_stall_cycles", stall_cycles, c_TO);
        chk("abort_pulses", abort_cnt, 32'd1);
`else
        for (int i = 0; i < 20; i++) cycle();
        chk("hold_stall_cycles", stall_cycles, 32'd20);
        chk("hold_no_abort", abort_cnt, 32'd0);
        chk("hold_grant", {29'd0, grant}, 32'd4);
        push_req(2, 8'h99, 1'b1);
        exp_q = '{8'h99};
        drive();
        drain(50, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
